fifo_burst_reader: RTL

//  Downstream consumer of the fifo block: drains it through its read/empty interface and presents the

---
 rtl/fifo_burst_reader_if.sv | 23 ++
 rtl/fifo_burst_reader.sv | 72 +++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Bundle of the fifo read port and the outgoing valid/ready stream of fifo_burst_reader.
// master = the reader (drives fifo_read and the stream); slave = the fifo/consumer side.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fifo_output_data;
  logic                  fifo_empty;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  fifo_output_data, fifo_empty, out_ready,
    output fifo_read, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_output_data, fifo_empty, out_ready,
    input  fifo_read, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a 1-cycle-latency fifo into a valid/ready stream through a 2-entry skid buffer,
// marking every BURST_LEN-th beat with out_last and counting completed bursts.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  fifo_burst_reader_if.master  bus,
  output logic [CNT_WIDTH-1:0] burst_count
);

  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] skid [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            buf_cnt;
  logic                  inflight;
  logic [BEAT_W-1:0]     beat;
  logic                  pop;
  logic                  push;
  logic                  fifo_read;
  logic [2:0]            occupancy;

  assign push = inflight;
  assign pop  = bus.out_valid & bus.out_ready;

  // Words already owned (buffered + in flight) after this cycle's pop; a read is safe below 2.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_read = en & ~bus.fifo_empty & ~reset & (occupancy < 3'd2);

  assign bus.fifo_read = fifo_read;
  assign bus.out_valid = (buf_cnt != 2'd0);
  assign bus.out_data  = (buf_cnt != 2'd0) ? skid[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid & (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight    <= 1'b0;
      buf_cnt     <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      beat        <= '0;
      burst_count <= '0;
      skid[0]     <= '0;
      skid[1]     <= '0;
    end else begin
      inflight <= fifo_read;
      if (push) begin
        skid[wr_ptr] <= bus.fifo_output_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (beat == LAST_BEAT) begin
          beat        <= '0;
          burst_count <= burst_count + CNT_WIDTH'(1);
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  a_buf_bound : assert property (@(posedge clk) disable iff (reset) buf_cnt <= 2'd2);

endmodule
